// File: rtl/snn_axi_pkg.sv
// Shared types and default sizing for the AXI-to-spike streaming blocks.
package snn_axi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_WORD_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/spike_stream_sched_if.sv
// FIFO read port and serial spike handshake between the scheduler (master)
// and its surroundings (slave).
interface spike_stream_sched_if
    import snn_axi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  spike_out;
    logic                  spike_valid;
    logic                  spike_ready;
    logic                  spike_last;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output spike_out,
        output spike_valid,
        output spike_last,
        input  spike_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  spike_out,
        input  spike_valid,
        input  spike_last,
        output spike_ready
    );

endinterface

// File: rtl/spike_shift_core.sv
// Word-to-bit shifter with its bit counter. Define SPIKE_LSB_FIRST_EN to emit
// bit 0 first; by default the MSB leaves first.
module spike_shift_core #(
    parameter int DATA_WIDTH = 64,
    parameter int BIT_CNT_W  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  spike_out,
    output logic                  spike_valid,
    output logic                  bit_last,
    output logic                  retire
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  valid_q;

    assign bit_last    = (bit_cnt == LAST_BIT);
    assign retire      = valid_q & ready & bit_last;
    assign spike_valid = valid_q;

`ifdef SPIKE_LSB_FIRST_EN
    assign spike_out = valid_q & shreg[0];
`else
    assign spike_out = valid_q & shreg[DATA_WIDTH-1];
`endif

    // The parent only asserts load when the register is empty or retiring,
    // so a load may overwrite the final bit of the previous word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
`ifdef SPIKE_LSB_FIRST_EN
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
`else
            shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
`endif
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_last) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spike_stream_sched.sv
// Drains spike words from the read-data FIFO into a counted, back-pressured
// bit-serial stream, prefetching one word ahead to avoid word-boundary bubbles.
module spike_stream_sched
    import snn_axi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WORD_CNT_W = DEFAULT_WORD_CNT_W,
    parameter int BIT_CNT_W  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_CNT_W-1:0] word_total,
    spike_stream_sched_if.master  bus,
    output logic                  busy,
    output logic                  done
);

    sched_state_t          state;
    logic [WORD_CNT_W-1:0] total;
    logic [WORD_CNT_W-1:0] rd_issued;
    logic [WORD_CNT_W-1:0] words_sent;
    logic                  rd_pending;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_word;

    logic                  core_out;
    logic                  core_valid;
    logic                  core_bit_last;
    logic                  core_retire;
    logic                  core_load;
    logic                  can_load;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] load_data;

    assign bus.fifo_rd_en = (state == RUN) & ~bus.fifo_empty & ~hold_valid &
                            ~rd_pending & (rd_issued < total);

    // Returning data bypasses the holding register when the shifter can take
    // it at once; that keeps first-bit latency at three cycles.
    assign can_load  = ~core_valid | core_retire;
    assign core_load = (state == RUN) & can_load & (hold_valid | rd_pending);
    assign load_data = hold_valid ? hold_word : bus.fifo_dout;
    assign last_word = (words_sent == total - WORD_CNT_W'(1));

    assign bus.spike_out   = core_out;
    assign bus.spike_valid = core_valid;
    assign bus.spike_last  = core_valid & core_bit_last & last_word;

    spike_shift_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (abort),
        .load        (core_load),
        .load_data   (load_data),
        .ready       (bus.spike_ready),
        .spike_out   (core_out),
        .spike_valid (core_valid),
        .bit_last    (core_bit_last),
        .retire      (core_retire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            total      <= '0;
            rd_issued  <= '0;
            words_sent <= '0;
            rd_pending <= 1'b0;
            hold_valid <= 1'b0;
            hold_word  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        rd_issued  <= '0;
                        words_sent <= '0;
                        rd_pending <= 1'b0;
                        hold_valid <= 1'b0;
                        if (word_total != '0) begin
                            total <= word_total;
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            total <= '0;
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        total      <= '0;
                        rd_issued  <= '0;
                        words_sent <= '0;
                        rd_pending <= 1'b0;
                        hold_valid <= 1'b0;
                    end else begin
                        rd_pending <= bus.fifo_rd_en;
                        if (bus.fifo_rd_en) begin
                            rd_issued <= rd_issued + WORD_CNT_W'(1);
                        end
                        // A read is only issued with the holding register
                        // empty, so it is free whenever data comes back.
                        if (rd_pending && !can_load) begin
                            hold_word  <= bus.fifo_dout;
                            hold_valid <= 1'b1;
                        end else if (core_load && hold_valid) begin
                            hold_valid <= 1'b0;
                        end
                        if (core_retire) begin
                            words_sent <= words_sent + WORD_CNT_W'(1);
                            if (last_word) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    total      <= '0;
                    rd_issued  <= '0;
                    words_sent <= '0;
                    rd_pending <= 1'b0;
                    hold_valid <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
